vga_timing_gen: RTL

- Generates VGA 640x480@60 raster timing from the 25.175 MHz pixel clock.
- Sits directly upstream of the colour/PCG mixer stage.
- Supplies the hsync, vsync and video_active that stage drives onto the TinyVGA PMOD.
- Also supplies pixel coordinates, line/frame strobes and a frame counter for pattern animation.

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_axis_counter.sv | 67 ++++++
 rtl/vga_timing_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing slice: default 640x480@60
// timing, total-period derivation and the coordinate width.
package vga_timing_pkg;

    // Coordinates are carried on 10-bit buses; one axis may span at most
    // this many positions.
    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    // Default 640x480@60 timing (25.175 MHz pixel clock).
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Frame counter load value at reset, so the first frame entered after
    // reset reads as frame 0.
    localparam logic [7:0] FRAME_CNT_RST = 8'hFF;

    // Total period of one axis: active region plus front porch, sync and
    // back porch.
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP,
                                            DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP,
                                            DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a position counter that wraps at ACTIVE+FP+SYNC+BP-1,
// plus decodes of the position it will hold after the current edge.
//
// pos        registered current position.
// wrap       combinational: this edge steps from the last position to 0.
// sync_on    next position lies inside the sync pulse.
// active_on  next position lies inside the visible region.
// start_on   next position is 0.
// The *_on decodes describe the value pos will load on this edge, so the
// parent can register them alongside pos with no skew between flag and
// coordinate.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    output logic [COORD_W-1:0] pos,
    output logic               wrap,
    output logic               sync_on,
    output logic               active_on,
    output logic               start_on
);

    localparam int TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_LO = ACTIVE + FP;
    localparam int SYNC_HI = ACTIVE + FP + SYNC;

    // Range limits are compared one bit wider than pos so an upper bound
    // equal to COORD_MAX still fits.
    localparam logic [COORD_W-1:0] LAST      = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W:0]   SYNC_LO_X = SYNC_LO[COORD_W:0];
    localparam logic [COORD_W:0]   SYNC_HI_X = SYNC_HI[COORD_W:0];
    localparam logic [COORD_W:0]   ACTIVE_X  = ACTIVE[COORD_W:0];

    logic [COORD_W-1:0] pos_next;
    logic [COORD_W:0]   next_x;

    // Next position and the decodes of that next position.
    always_comb begin
        wrap      = step && (pos == LAST);
        pos_next  = pos;
        if (step) begin
            pos_next = wrap ? '0 : pos + 1'b1;
        end
        next_x    = {1'b0, pos_next};
        sync_on   = (next_x >= SYNC_LO_X) && (next_x < SYNC_HI_X);
        active_on = (next_x < ACTIVE_X);
        start_on  = (pos_next == '0);
    end

    // Position register; reset parks on the last position so the first
    // step lands on 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= LAST;
        end else begin
            pos <= pos_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Produces registered hsync/vsync/video_active,
// pixel coordinates, line/frame strobes and a free-running frame counter.
// Every output describes the currently held (hpos, vpos): counters and
// flags load together from the same next-position decode on each enabled
// edge, so there is no skew and no combinational path to any output.
//
// en is a plain advance qualifier, not a handshake: when en=1 at a rising
// edge the raster advances by one pixel; when en=0 every output register
// holds. rst overrides en.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                hsync,
    output logic                vsync,
    output logic                video_active,
    output logic [COORD_W-1:0]  hpos,
    output logic [COORD_W-1:0]  vpos,
    output logic                line_start,
    output logic                frame_start,
    output logic [7:0]          frame_cnt
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Coordinates are 10 bits wide; longer periods cannot be represented.
    generate
        if (H_TOTAL > COORD_MAX) begin : g_h_total_too_large
            $error("vga_timing_gen: H_TOTAL exceeds coordinate range");
        end
        if (V_TOTAL > COORD_MAX) begin : g_v_total_too_large
            $error("vga_timing_gen: V_TOTAL exceeds coordinate range");
        end
    endgenerate

    logic h_wrap, h_sync_on, h_active_on, h_start_on;
    logic v_wrap, v_sync_on, v_active_on, v_start_on;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk       (clk),
        .rst       (rst),
        .step      (en),
        .pos       (hpos),
        .wrap      (h_wrap),
        .sync_on   (h_sync_on),
        .active_on (h_active_on),
        .start_on  (h_start_on)
    );

    // The vertical axis advances once per completed line.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk       (clk),
        .rst       (rst),
        .step      (h_wrap),
        .pos       (vpos),
        .wrap      (v_wrap),
        .sync_on   (v_sync_on),
        .active_on (v_active_on),
        .start_on  (v_start_on)
    );

    // Output flag and frame counter registers, loaded from the decode of
    // the position the counters move to on this same edge. Sync polarity
    // is applied only here. A vertical wrap is exactly an entry into (0,0),
    // including the first edge after reset, which is why frame_cnt counts
    // on it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync        <= ~SYNC_ACTIVE;
            vsync        <= ~SYNC_ACTIVE;
            video_active <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            frame_cnt    <= FRAME_CNT_RST;
        end else if (en) begin
            hsync        <= h_sync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync        <= v_sync_on ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_active <= h_active_on & v_active_on;
            line_start   <= h_start_on;
            frame_start  <= h_start_on & v_start_on;
            if (v_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
